// File: rtl/cv32e40p_ft_pkg.sv
// Shared definitions for the ALU permanent-fault detector.
//   NUM_ALU      : number of ALU replicas watched by the TMR voter.
//   POP_W        : width wide enough to hold a popcount over NUM_ALU bits.
//   alu_health_e : per-lane health state (HEALTHY / SUSPECT / FAULTY).
//   popcount_alu : number of set bits in a NUM_ALU-wide vector.
package cv32e40p_ft_pkg;

  localparam int NUM_ALU = 4;
  localparam int POP_W   = $clog2(NUM_ALU + 1);

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULTY  = 2'd2
  } alu_health_e;

  function automatic logic [POP_W-1:0] popcount_alu(input logic [NUM_ALU-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cv32e40p_alu_fault_counter.sv
// One ALU lane of the permanent-fault detector: health FSM, saturating
// error counter and (optionally) a leaky-bucket decay counter.
//
// Optional feature: define FT_ALU_FAULT_DECAY_EN to let clean samples in
// SUSPECT slowly bleed the error count back down.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   clear_i    in   clear all lane state (wins over a simultaneous error)
//   qual_i     in   this lane is sampled this cycle (valid and active)
//   err_i      in   voter mismatch for this lane (used only when qual_i=1)
//   state_o    out  current FSM state (debug / flag generation)
//   faulty_d_o out  next-state is FAULTY (lets the top register the
//                   event and TMR-lost outputs aligned with the flag)
module cv32e40p_alu_fault_counter
  import cv32e40p_ft_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int THRESHOLD    = 8,
  parameter int DECAY_PERIOD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        qual_i,
  input  logic        err_i,
  output alu_health_e state_o,
  output logic        faulty_d_o
);

  // Elaboration-time parameter range checks.
  if (THRESHOLD < 2 || THRESHOLD > (2 ** CNT_W) - 1) begin : g_bad_threshold
    $error("THRESHOLD out of range for CNT_W");
  end
  if (DECAY_PERIOD < 2) begin : g_bad_decay
    $error("DECAY_PERIOD must be at least 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  alu_health_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

`ifdef FT_ALU_FAULT_DECAY_EN
  localparam int DCNT_W = $clog2(DECAY_PERIOD);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_PERIOD - 1);
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
`endif

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HEALTHY;
      cnt_q   <= '0;
`ifdef FT_ALU_FAULT_DECAY_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef FT_ALU_FAULT_DECAY_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  // Next-state logic. Unqualified cycles hold everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef FT_ALU_FAULT_DECAY_EN
    dcnt_d  = dcnt_q;
`endif
    if (clear_i) begin
      state_d = HEALTHY;
      cnt_d   = '0;
`ifdef FT_ALU_FAULT_DECAY_EN
      dcnt_d  = '0;
`endif
    end else if (qual_i) begin
      unique case (state_q)
        HEALTHY: begin
          if (err_i) begin
            state_d = SUSPECT;
            cnt_d   = CNT_ONE;
          end
        end
        SUSPECT: begin
          if (err_i) begin
            cnt_d = cnt_inc;
`ifdef FT_ALU_FAULT_DECAY_EN
            dcnt_d = '0;
`endif
            if (cnt_inc >= CNT_THR) begin
              state_d = FAULTY;
            end
          end
`ifdef FT_ALU_FAULT_DECAY_EN
          else if (dcnt_q == DCNT_LAST) begin
            // A full decay period of clean samples forgives one error.
            dcnt_d = '0;
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_d = HEALTHY;
            end
          end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
          end
`endif
        end
        FAULTY: begin
          // Sticky until clear or reset.
        end
        default: begin
          state_d = HEALTHY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs.
  always_comb begin
    state_o    = state_q;
    faulty_d_o = (state_d == FAULTY);
  end

endmodule

// File: rtl/cv32e40p_alu_permanent_fault_detector.sv
// Permanent-fault detector for the TMR ALU replicas. Each lane counts voter
// mismatches and is declared permanently faulty after THRESHOLD of them;
// the top combines the lanes into the fault flags, a one-cycle rise event
// and a "TMR lost" indication (two or more lanes faulty).
//
// Optional feature: define FT_ALU_FAULT_DECAY_EN for leaky-bucket decay of
// the per-lane error counts.
//
// Handshake: valid_i is a pure qualifier with no back-pressure; a lane is
// sampled in every cycle where valid_i=1 and its active_alu_i bit is set.
//
// Ports:
//   clk                    in   clock, rising edge
//   rst                    in   synchronous active-high reset
//   valid_i                in   voter result valid this cycle
//   err_alu_i[3:0]         in   per-ALU voter mismatch flags
//   active_alu_i[3:0]      in   ALUs currently in the TMR set
//   clear_i                in   clear all fault state
//   permanent_faulty_alu_o out  sticky per-ALU permanent-fault flags
//   fault_event_o          out  one-cycle pulse when any flag newly sets
//   tmr_lost_o             out  two or more ALUs flagged faulty
module cv32e40p_alu_permanent_fault_detector
  import cv32e40p_ft_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int THRESHOLD    = 8,
  parameter int DECAY_PERIOD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [NUM_ALU-1:0] err_alu_i,
  input  logic [NUM_ALU-1:0] active_alu_i,
  input  logic               clear_i,
  output logic [NUM_ALU-1:0] permanent_faulty_alu_o,
  output logic               fault_event_o,
  output logic               tmr_lost_o
);

  alu_health_e        lane_state [NUM_ALU];
  logic [NUM_ALU-1:0] faulty_d;
  logic               fault_event_d, fault_event_q;
  logic               tmr_lost_d, tmr_lost_q;

  for (genvar i = 0; i < NUM_ALU; i++) begin : g_lane
    cv32e40p_alu_fault_counter #(
      .CNT_W        (CNT_W),
      .THRESHOLD    (THRESHOLD),
      .DECAY_PERIOD (DECAY_PERIOD)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear_i),
      .qual_i     (valid_i & active_alu_i[i]),
      .err_i      (err_alu_i[i]),
      .state_o    (lane_state[i]),
      .faulty_d_o (faulty_d[i])
    );
  end

  // Flags come straight from the registered lane states.
  always_comb begin
    for (int i = 0; i < NUM_ALU; i++) begin
      permanent_faulty_alu_o[i] = (lane_state[i] == FAULTY);
    end
  end

  // Event and TMR-lost are computed from next-state flags and registered so
  // they line up with the flag outputs. Clear forces faulty_d to zero, so it
  // can never produce an event.
  assign fault_event_d = |(faulty_d & ~permanent_faulty_alu_o);
  assign tmr_lost_d    = (popcount_alu(faulty_d) >= POP_W'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_event_q <= 1'b0;
      tmr_lost_q    <= 1'b0;
    end else begin
      fault_event_q <= fault_event_d;
      tmr_lost_q    <= tmr_lost_d;
    end
  end

  assign fault_event_o = fault_event_q;
  assign tmr_lost_o    = tmr_lost_q;

endmodule

// File: doc/cv32e40p_alu_permanent_fault_detector.md
CV32E40P_ALU_PERMANENT_FAULT_DETECTOR -- requirements
Module: cv32e40p_alu_permanent_fault_detector

Interface
REQ-001 Parameter CNT_W, default 4: width of each per-ALU error counter.
REQ-002 Parameter THRESHOLD, default 8: error count at which an ALU is declared permanently faulty; legal range 2..2^CNT_W-1.
REQ-003 Parameter DECAY_PERIOD, default 16: number of clean qualified samples per counter decrement; legal range >=2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 valid_i  input  1  the voter comparison result for the current instruction is valid this cycle.
REQ-007 err_alu_i  input  4  per-ALU mismatch flag from the TMR voter; meaningful only when valid_i=1.
REQ-008 active_alu_i  input  4  ALUs currently in the TMR set (the replica clock-gate mask); non-active lanes are not observed.
REQ-009 clear_i  input  1  software/debug clear of all fault state.
REQ-010 permanent_faulty_alu_o  output  4  sticky per-ALU permanent-fault flags; feeds the faulty-ALU decoder.
REQ-011 fault_event_o  output  1  one-cycle pulse when any ALU flag newly sets.
REQ-012 tmr_lost_o  output  1  two or more ALUs are flagged faulty.

Function
REQ-013 A lane is qualified in a cycle when valid_i=1 and active_alu_i[i]=1; unqualified lanes hold all state.
REQ-014 Each lane implements FSM HEALTHY / SUSPECT / FAULTY with counter cnt[i] (CNT_W bits).
REQ-015 HEALTHY (cnt=0): qualified error -> cnt=1, SUSPECT; qualified clean sample -> stay.
REQ-016 SUSPECT: qualified error -> cnt+1 and decay counter reset to 0; if cnt+1 >= THRESHOLD -> FAULTY.
REQ-017 FAULTY: sticky; cnt holds; only clear_i or rst leave it (to HEALTHY, cnt=0).
REQ-018 permanent_faulty_alu_o[i] is 1 exactly when lane i is in FAULTY; registered, asserted the cycle after the THRESHOLD-th qualified error is sampled.
REQ-019 cnt never wraps: saturates at 2^CNT_W-1.
REQ-020 fault_event_o is 1 for exactly one cycle, the same cycle any permanent_faulty_alu_o bit rises; multiple lanes rising together give one pulse.
REQ-021 tmr_lost_o is registered and equals (popcount of next-state FAULTY flags >= 2), aligned with permanent_faulty_alu_o.
REQ-022 clear_i has priority over a simultaneous error: all lanes -> HEALTHY, cnt=0, decay counters=0, no fault_event_o pulse next cycle.
REQ-023 Lanes are fully independent; simultaneous errors on several lanes are each counted.

Reset
REQ-024 On rst=1 at a rising edge: all lanes HEALTHY, all cnt and decay counters 0, permanent_faulty_alu_o=4'b0000, fault_event_o=0, tmr_lost_o=0.
REQ-025 rst asserted mid-accumulation discards all progress; no partial count survives.

Configuration
REQ-026 Macro FT_ALU_FAULT_DECAY_EN enables leaky-bucket decay.
REQ-027 With the macro: in SUSPECT each qualified clean sample increments a per-lane decay counter; on reaching DECAY_PERIOD clean samples, cnt decrements by 1 and the decay counter returns to 0; cnt reaching 0 -> HEALTHY.
REQ-028 Without the macro: no decay logic exists; cnt only increments, so THRESHOLD errors at any spacing declare FAULTY.

Structure
REQ-029 Shared package cv32e40p_ft_pkg holds NUM_ALU=4 and enum alu_health_e {HEALTHY, SUSPECT, FAULTY}.
REQ-030 Per-lane FSM, counter and decay counter live in sub-module cv32e40p_alu_fault_counter, instantiated NUM_ALU times; top holds event/popcount logic.

Verification
REQ-031 8 consecutive qualified errors on lane 1 (active=4'b0111) -> permanent_faulty_alu_o=4'b0010 one cycle after the 8th, fault_event_o pulses once.
REQ-032 Errors on lane 3 with active=4'b0111 (lane 3 inactive) for 20 cycles -> outputs remain 4'b0000.
REQ-033 Decay on: 7 errors on lane 0, then 16x7=112 clean qualified samples -> lane 0 back to HEALTHY, flag never sets; decay off: same then 1 error -> flag 4'b0001.
REQ-034 Lanes 0 and 2 reach threshold in the same cycle -> flags 4'b0101, tmr_lost_o=1, single fault_event_o pulse.
REQ-035 clear_i coincident with the 8th error on lane 1 -> flags stay 4'b0000, no pulse; rst during count of 5 -> 8 further errors needed.
